// File: rtl/binary_bcd_converter.sv
// Sequential binary-to-BCD converter using double dabble, one bit per clock.
// O_BCD only changes when a conversion completes, so downstream displays never see partial digits.
module binary_bcd_converter #(
  parameter int N_BITS   = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                    I_CLK,
  input  logic                    I_NRESET,
  input  logic                    I_START,
  input  logic [N_BITS-1:0]       I_BINARY,
  output logic [4*N_DIGITS-1:0]   O_BCD,
  output logic                    O_BUSY,
  output logic                    O_DONE
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [N_BITS-1:0]  shift_reg;
  logic [BCD_W-1:0]   scratch_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W-1:0]   scratch_next;

  // Per-digit add-3 correction; 4-bit adders, the range constraint keeps digits below 10.
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign adjusted[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                   ? scratch_reg[4*gi +: 4] + 4'd3
                                   : scratch_reg[4*gi +: 4];
    end
  endgenerate

  // The top scratch bit shifted out is always zero for in-range inputs.
  assign scratch_next = BCD_W'({adjusted, shift_reg[N_BITS-1]});

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      scratch_reg <= '0;
      bcd_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (I_START) begin
            shift_reg   <= I_BINARY;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            state_reg   <= SHIFT;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
          end else begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
          end
        end
        SHIFT: begin
          scratch_reg <= scratch_next;
          shift_reg   <= shift_reg << 1;
          cnt_reg     <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_ITER) begin
            bcd_reg   <= scratch_next;
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign O_BCD  = bcd_reg;
  assign O_BUSY = busy_reg;
  assign O_DONE = done_reg;

endmodule

// File: tb/tb_binary_bcd_converter.sv
// Directed and random-sweep bench for binary_bcd_converter: result digits, latency, busy/done timing,
// ignored restarts, back-to-back starts and asynchronous reset abort.
module tb_binary_bcd_converter;

  localparam int N_BITS   = 16;
  localparam int N_DIGITS = 5;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [N_BITS-1:0]     bin;
  logic [4*N_DIGITS-1:0] bcd;
  logic                  busy;
  logic                  done;

  int checks   = 0;
  int failures = 0;
  logic [4*N_DIGITS-1:0] last_bcd = '0;

  binary_bcd_converter #(.N_BITS(N_BITS), .N_DIGITS(N_DIGITS)) dut (
    .I_CLK    (clk),
    .I_NRESET (rst_n),
    .I_START  (start),
    .I_BINARY (bin),
    .O_BCD    (bcd),
    .O_BUSY   (busy),
    .O_DONE   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*N_DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*N_DIGITS-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [4*N_DIGITS-1:0] v);
    for (int i = 0; i < N_DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Full conversion: checks busy duration, output hold while busy, latency, result and single done pulse.
  task automatic convert(input int unsigned val, input bit verbose);
    int cyc;
    int busy_cnt;
    logic [4*N_DIGITS-1:0] exp;
    exp = ref_bcd(val);
    @(negedge clk);
    start = 1'b1;
    bin   = N_BITS'(val);
    @(negedge clk);
    start = 1'b0;
    bin   = ~bin;
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (bcd !== last_bcd) check("hold_while_busy", bcd, last_bcd);
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1'b1);
    check("latency", cyc, N_BITS + 1);
    check("busy_cycles", busy_cnt, N_BITS);
    check("result", bcd, exp);
    check("digits_le_9", digits_ok(bcd), 1'b1);
    last_bcd = exp;
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    if (verbose)
      $display("convert %0d -> bcd 0x%05h (latency %0d)", val, bcd, cyc);
  endtask

  initial begin
    int cyc;
    int unsigned sweep_vals[5] = '{0, 1, 9, 10, 65535};
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #12;
    check("reset_bcd", bcd, 20'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values with hand-computed digits.
    convert(0, 1'b1);
    check("zero_lit", bcd, 20'h00000);
    convert(65535, 1'b1);
    check("max_lit", bcd, 20'h65535);
    convert(1234, 1'b1);
    check("1234_lit", bcd, 20'h01234);
    convert(9999, 1'b1);
    check("9999_lit", bcd, 20'h09999);

    // Restart attempt during SHIFT is ignored.
    @(negedge clk);
    start = 1'b1; bin = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; bin = 16'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    check("ignore_start_bcd", bcd, 20'h04321);
    @(negedge clk);
    check("ignore_start_single_done", done, 1'b0);
    check("ignore_start_no_busy", busy, 1'b0);
    $display("ignored restart -> bcd 0x%05h", bcd);

    // Start held high through DONE chains a second conversion.
    @(negedge clk);
    start = 1'b1; bin = 16'd100;
    @(negedge clk);
    bin = 16'd200;
    cyc = 0;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    check("b2b_first_bcd", bcd, 20'h00100);
    check("b2b_first_busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_rebusy", busy, 1'b1);
    check("b2b_done_dropped", done, 1'b0);
    cyc = 1;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    check("b2b_second_latency", cyc, N_BITS + 1);
    check("b2b_second_bcd", bcd, 20'h00200);
    $display("back-to-back 100,200 -> bcd 0x%05h", bcd);
    last_bcd = 20'h00200;
    @(negedge clk);

    // Asynchronous reset aborts a conversion in progress.
    convert(42, 1'b1);
    @(negedge clk);
    start = 1'b1; bin = 16'd999;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_bcd", bcd, 20'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cyc++;
    end
    check("abort_no_done", cyc, 0);
    $display("reset abort -> bcd 0x%05h", bcd);
    last_bcd = '0;
    convert(5, 1'b1);
    check("after_reset_bcd", bcd, 20'h00005);

    // Boundary values then a random sweep against the decimal reference.
    foreach (sweep_vals[i]) convert(sweep_vals[i], 1'b1);
    for (int i = 0; i < 1000; i++) convert($urandom_range(65535, 0), 1'b0);
    $display("random sweep of 1000 values complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_bcd_converter.md
BINARY_BCD_CONVERTER -- requirements
Module: binary_bcd_converter

Interface
REQ-001 The block SHALL have parameter N_BITS, default 16, giving the binary input width.
REQ-002 The block SHALL have parameter N_DIGITS, default 5, giving the number of BCD output digits; 10^N_DIGITS SHALL exceed 2^N_BITS-1.
REQ-003 The block SHALL have port I_CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port I_NRESET, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port I_START, input, 1 bit: conversion request, sampled on the rising edge.
REQ-006 The block SHALL have port I_BINARY, input, N_BITS bits: unsigned value, sampled only on the edge that accepts I_START.
REQ-007 The block SHALL have port O_BCD, output, 4*N_DIGITS bits: packed BCD result; digit 0 (units) in bits [3:0]; each nibble drives one downstream seven-segment mapping.
REQ-008 The block SHALL have port O_BUSY, output, 1 bit: high while a conversion is in progress.
REQ-009 The block SHALL have port O_DONE, output, 1 bit: one-cycle pulse; O_BCD newly valid.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-011 IDLE or DONE with I_START=1 at an edge: latch I_BINARY into a shift register, clear the BCD scratch register, clear the iteration counter, enter SHIFT.
REQ-012 IDLE with I_START=0: stay IDLE. DONE with I_START=0: go to IDLE.
REQ-013 Each SHIFT edge SHALL perform one double-dabble iteration: add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one bit, with the binary MSB entering scratch bit 0.
REQ-014 The counter SHALL count 0..N_BITS-1. The edge performing iteration N_BITS-1 SHALL load the final scratch value into O_BCD and enter DONE.
REQ-015 Latency: start accepted at edge k -> O_BCD updated and O_DONE high in the cycle after edge k+N_BITS (N_BITS+1 cycles; 17 cycles at default).
REQ-016 O_BUSY SHALL equal 1 exactly while in SHIFT; O_DONE SHALL equal 1 exactly while in DONE. Both outputs are registered state decodes.
REQ-017 I_START while in SHIFT SHALL be ignored; I_BINARY changes after acceptance SHALL NOT affect the result.
REQ-018 I_START in the DONE cycle SHALL start a new conversion; O_DONE still pulses for exactly that one cycle (back-to-back throughput N_BITS+1 cycles).
REQ-019 O_BCD SHALL hold its last result, unchanged, in IDLE, SHIFT and DONE until the next REQ-014 load; intermediate scratch values SHALL never appear on O_BCD.
REQ-020 Every O_BCD nibble SHALL be in 0..9 at all times.
REQ-021 Digit adders SHALL be 4 bits wide with no carry out. With the REQ-002 constraint, a digit is never >= 10 after shifting.

Reset
REQ-022 While I_NRESET=0, regardless of the clock: state=IDLE; counter, shift and scratch registers = 0; O_BCD=0; O_BUSY=0; O_DONE=0.
REQ-023 Reset asserted mid-conversion SHALL abort it: no O_DONE, O_BCD=0. After release, the first accepted I_START SHALL behave per REQ-011.

Verification
REQ-024 I_BINARY=0, pulse I_START -> O_BUSY high for 16 cycles, O_DONE one cycle, O_BCD=0x00000.
REQ-025 I_BINARY=65535 -> O_BCD=0x65535. I_BINARY=1234 -> 0x01234. I_BINARY=9999 -> 0x09999.
REQ-026 Start 4321, then pulse I_START with I_BINARY=7 at cycle 5 of SHIFT -> second start ignored; O_BCD=0x04321; O_DONE single pulse.
REQ-027 Start 100, hold I_START high through DONE with I_BINARY=200 -> O_DONE for 100 (O_BCD=0x00100), O_BUSY re-asserts the next cycle, then O_DONE with O_BCD=0x00200.
REQ-028 After O_BCD=0x00042, start 999 and drop I_NRESET at SHIFT cycle 8 -> O_BCD=0 and outputs low immediately; no O_DONE. After release, start 5 -> O_BCD=0x00005.
REQ-029 Random I_BINARY sweep (>=1000 values plus 0, 1, 9, 10, 65535) -> O_BCD matches the reference decimal digits; nibbles always <= 9; latency exactly 17 cycles.
